mem_sys: RTL and testbench

- Memory subsystem directly downstream of the multi-cycle CPU's memory port: consumes adr, writedata and MemWrite; produces readdata.
- Holds unified instruction/data RAM plus a small MMIO block: LED output register, synchronised switch input, a 32-bit compare timer with interrupt flag, and a sticky bus-error status.
- The CPU latches readdata at the end of the same cycle adr is presented, so reads are combinational and writes are clocked.

---
 rtl/mem_sys.sv | 111 +++++++++++
 tb/tb_mem_sys.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_sys.sv
// mem_sys: unified RAM plus LED/switch/timer/error MMIO behind a combinational-read CPU port
module mem_sys #(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        MemWrite,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq,
    output logic        err
);
    localparam logic [7:0] OFF_LED = 8'h00, OFF_SW = 8'h04, OFF_TCNT = 8'h08,
                           OFF_TCMP = 8'h0C, OFF_TCTRL = 8'h10, OFF_ERR = 8'h14;

    logic [31:0]       r_mem [0:2**ADDR_W-1];
    logic [15:0]       r_led, r_sw1, r_sw2;
    logic [31:0]       r_tcnt, r_tcmp;
    logic              r_en, r_ar, r_flag, r_ie, r_irq, r_err;
    logic              w_ram, w_mmio, w_ok, w_bad, w_match, w_unused;
    logic              w_wr_led, w_wr_tcnt, w_wr_tcmp, w_wr_tctrl, w_wr_err;
    logic              w_flag_nx, w_ie_nx, w_err_nx;
    logic [7:0]        w_off;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_tcnt_nx, w_rdata;

    assign w_ram    = adr[31:16] == 16'h0;
    assign w_mmio   = adr[31:16] == MMIO_PAGE && adr[15:8] == 8'h0;
    assign w_off    = {adr[7:2], 2'b00};
    assign w_idx    = adr[ADDR_W+1:2];
    assign w_unused = ^adr[1:0];

    assign w_wr_led   = MemWrite & w_mmio & (w_off == OFF_LED);
    assign w_wr_tcnt  = MemWrite & w_mmio & (w_off == OFF_TCNT);
    assign w_wr_tcmp  = MemWrite & w_mmio & (w_off == OFF_TCMP);
    assign w_wr_tctrl = MemWrite & w_mmio & (w_off == OFF_TCTRL);
    assign w_wr_err   = MemWrite & w_mmio & (w_off == OFF_ERR);
    assign w_ok  = w_ram | (w_mmio & (w_off == OFF_LED || w_off == OFF_TCNT ||
                   w_off == OFF_TCMP || w_off == OFF_TCTRL || w_off == OFF_ERR));
    assign w_bad = MemWrite & ~w_ok;

    // CPU write to TCNT beats the count; hardware flag set beats a write-1 clear
    assign w_match   = r_en & (r_tcnt == r_tcmp);
    assign w_tcnt_nx = w_wr_tcnt ? writedata :
                       !r_en ? r_tcnt :
                       (w_match & r_ar) ? 32'h0 : r_tcnt + 32'h1;
    assign w_flag_nx = w_match | (r_flag & ~(w_wr_tctrl & writedata[2]));
    assign w_ie_nx   = w_wr_tctrl ? writedata[3] : r_ie;
    assign w_err_nx  = w_bad | (r_err & ~(w_wr_err & writedata[0]));

    always_comb begin
        w_rdata = 32'h0;
        if (w_ram)
            w_rdata = r_mem[w_idx];
        else if (w_mmio)
            case (w_off)
                OFF_LED:   w_rdata = {16'h0, r_led};
                OFF_SW:    w_rdata = {16'h0, r_sw2};
                OFF_TCNT:  w_rdata = r_tcnt;
                OFF_TCMP:  w_rdata = r_tcmp;
                OFF_TCTRL: w_rdata = {28'h0, r_ie, r_flag, r_ar, r_en};
                OFF_ERR:   w_rdata = {31'h0, r_err};
                default:   w_rdata = 32'h0;
            endcase
    end

    always_ff @(posedge clk)
        if (rst && MemWrite && w_ram)
            r_mem[w_idx] <= writedata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_led  <= 16'h0;
            r_sw1  <= 16'h0;
            r_sw2  <= 16'h0;
            r_tcnt <= 32'h0;
            r_tcmp <= 32'hFFFF_FFFF;
            r_en   <= 1'b0;
            r_ar   <= 1'b0;
            r_ie   <= 1'b0;
            r_flag <= 1'b0;
            r_irq  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr_led)
                r_led <= writedata[15:0];
            r_sw1  <= sw;
            r_sw2  <= r_sw1;
            r_tcnt <= w_tcnt_nx;
            if (w_wr_tcmp)
                r_tcmp <= writedata;
            if (w_wr_tctrl) begin
                r_en <= writedata[0];
                r_ar <= writedata[1];
            end
            r_ie   <= w_ie_nx;
            r_flag <= w_flag_nx;
            r_irq  <= w_flag_nx & w_ie_nx;
            r_err  <= w_err_nx;
        end
    end

    assign readdata = w_rdata;
    assign led      = r_led;
    assign irq      = r_irq;
    assign err      = r_err;
endmodule

// File: tb/tb_mem_sys.sv
// tb_mem_sys: directed checks of RAM, LED, switch sync, timer, error flag and reset
module tb_mem_sys;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, writedata, readdata;
    logic        MemWrite;
    logic [15:0] sw, led;
    logic        irq, err;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] v;

    localparam logic [31:0] A_LED = 32'hFFFF_0000, A_SW = 32'hFFFF_0004, A_TCNT = 32'hFFFF_0008,
                            A_TCMP = 32'hFFFF_000C, A_TCTRL = 32'hFFFF_0010, A_ERR = 32'hFFFF_0014;

    mem_sys #(.ADDR_W(10), .MMIO_PAGE(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .adr(adr), .writedata(writedata), .MemWrite(MemWrite),
        .readdata(readdata), .sw(sw), .led(led), .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr = a;
        writedata = d;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        adr = a;
        MemWrite = 1'b0;
        #1;
        d = readdata;
    endtask

    initial begin
        rst = 1'b0; MemWrite = 1'b0; adr = 32'h0; writedata = 32'h0; sw = 16'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rd(A_TCNT, v);  chk("rst_tcnt", v, 32'h0);
        rd(A_TCMP, v);  chk("rst_tcmp", v, 32'hFFFF_FFFF);
        rd(A_TCTRL, v); chk("rst_tctrl", v, 32'h0);
        // RAM write: old value visible during the write cycle, new one after, aliasing
        wr(32'h10, 32'h1111_1111);
        adr = 32'h10; writedata = 32'hDEAD_BEEF; MemWrite = 1'b1;
        #1 chk("ram_old_in_wr_cycle", readdata, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        rd(32'h10, v);   chk("ram_new", v, 32'hDEAD_BEEF);
        rd(32'h1010, v); chk("ram_alias", v, 32'hDEAD_BEEF);
        wr(32'h14, 32'hCAFE_F00D);
        rd(32'h14, v);   chk("ram_other_word", v, 32'hCAFE_F00D);
        rd(32'h10, v);   chk("ram_kept", v, 32'hDEAD_BEEF);
        // LED and switch synchroniser
        wr(A_LED, 32'h0000_A5A5);
        chk("led_port", {16'h0, led}, 32'h0000_A5A5);
        rd(A_LED, v); chk("led_read", v, 32'h0000_A5A5);
        sw = 16'h1234;
        rd(A_SW, v); chk("sw_lat0", v, 32'h0);
        tick();
        rd(A_SW, v); chk("sw_lat1", v, 32'h0);
        tick();
        rd(A_SW, v); chk("sw_lat2", v, 32'h1234);
        // timer with autoreload and interrupt
        wr(A_TCMP, 32'd5);
        wr(A_TCNT, 32'd0);
        wr(A_TCTRL, 32'hB);
        rd(A_TCNT, v); chk("t1_start", v, 32'd0);
        repeat (5) tick();
        rd(A_TCNT, v);  chk("t1_at5", v, 32'd5);
        rd(A_TCTRL, v); chk("t1_noflag", v, 32'hB);
        chk("t1_noirq", {31'h0, irq}, 32'h0);
        tick();
        rd(A_TCNT, v);  chk("t1_reload", v, 32'd0);
        rd(A_TCTRL, v); chk("t1_flag", v, 32'hF);
        chk("t1_irq", {31'h0, irq}, 32'h1);
        wr(A_TCTRL, 32'hF);
        rd(A_TCTRL, v); chk("t1_flag_clr", v, 32'hB);
        chk("t1_irq_clr", {31'h0, irq}, 32'h0);
        rd(A_TCNT, v);  chk("t1_cnt_after", v, 32'd1);
        wr(A_TCTRL, 32'h0);
        // timer wrap, no autoreload, write priority, set-beats-clear, freeze
        wr(A_TCMP, 32'd3);
        wr(A_TCNT, 32'hFFFF_FFFE);
        wr(A_TCTRL, 32'h1);
        rd(A_TCNT, v); chk("t2_fffe", v, 32'hFFFF_FFFE);
        tick(); rd(A_TCNT, v); chk("t2_ffff", v, 32'hFFFF_FFFF);
        tick(); rd(A_TCNT, v); chk("t2_wrap0", v, 32'd0);
        tick(); rd(A_TCNT, v); chk("t2_1", v, 32'd1);
        tick(); tick();
        rd(A_TCNT, v);  chk("t2_3", v, 32'd3);
        rd(A_TCTRL, v); chk("t2_noflag", v, 32'h1);
        tick();
        rd(A_TCNT, v);  chk("t2_4", v, 32'd4);
        rd(A_TCTRL, v); chk("t2_flag", v, 32'h5);
        chk("t2_noirq_ie0", {31'h0, irq}, 32'h0);
        wr(A_TCNT, 32'd100);
        rd(A_TCNT, v); chk("t2_wr_prio", v, 32'd100);
        wr(A_TCMP, 32'd101);
        wr(A_TCTRL, 32'h5);
        rd(A_TCTRL, v); chk("t2_set_wins", v, 32'h5);
        wr(A_TCTRL, 32'h4);
        rd(A_TCTRL, v); chk("t2_stopped", v, 32'h0);
        rd(A_TCNT, v);  chk("t2_cnt", v, 32'd103);
        tick();
        rd(A_TCNT, v);  chk("t2_frozen", v, 32'd103);
        // bus errors
        wr(32'h1234_0000, 32'h5555_5555);
        chk("err_unmapped", {31'h0, err}, 32'h1);
        rd(32'h1234_0000, v); chk("unmapped_rd0", v, 32'h0);
        rd(32'h10, v);        chk("err_ram_kept", v, 32'hDEAD_BEEF);
        wr(A_ERR, 32'h0);
        chk("err_wr0_keeps", {31'h0, err}, 32'h1);
        wr(A_ERR, 32'h1);
        chk("err_clr", {31'h0, err}, 32'h0);
        wr(A_SW, 32'hFFFF);
        chk("err_ro", {31'h0, err}, 32'h1);
        rd(A_SW, v);  chk("sw_kept", v, 32'h1234);
        rd(A_ERR, v); chk("err_read", v, 32'h1);
        wr(A_ERR, 32'h1);
        wr(32'hFFFF_0100, 32'h1111);
        chk("err_hi_off", {31'h0, err}, 32'h1);
        chk("led_kept", {16'h0, led}, 32'h0000_A5A5);
        rd(32'hFFFF_0100, v); chk("hi_off_rd0", v, 32'h0);
        wr(A_ERR, 32'h1);
        rd(32'hFFFF_0018, v); chk("unmapped_off_rd0", v, 32'h0);
        tick();
        chk("rd_no_err", {31'h0, err}, 32'h0);
        // reset overrides pending write and running timer
        wr(A_TCMP, 32'h0);
        wr(A_TCNT, 32'h0);
        wr(A_TCTRL, 32'h9);
        tick();
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        wr(32'h1234_0000, 32'h0);
        chk("pre_rst_err", {31'h0, err}, 32'h1);
        rst = 1'b0; adr = A_LED; writedata = 32'hFFFF; MemWrite = 1'b1;
        tick();
        rst = 1'b1; MemWrite = 1'b0;
        chk("mid_rst_led", {16'h0, led}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        rd(A_TCNT, v);  chk("mid_rst_tcnt", v, 32'h0);
        rd(A_TCMP, v);  chk("mid_rst_tcmp", v, 32'hFFFF_FFFF);
        rd(A_TCTRL, v); chk("mid_rst_tctrl", v, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
